usb_ep2_cmd_decoder: RTL

Sits directly downstream of the EP2 read path of the CY68013 slave-FIFO interface. It consumes the 16-bit words read out of EP2 and parses them into framed commands. Payload is buffered until the frame checksum is verified; only then are register writes or the LED update committed. Frame status pulses and counters are provided for the EP6 return path and for debug.

---
 rtl/usb_ep2_cmd_decoder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/usb_ep2_cmd_decoder.sv
// Parses EP2 words into checksummed command frames and commits LED or register writes once the frame verifies.
// Commit writes start the cycle after the CHK word; in_ready is low only while a commit drains.
module usb_ep2_cmd_decoder #(
  parameter int          MAX_LEN   = 16,
  parameter logic [15:0] SYNC_WORD = 16'h55AA,
  parameter int          TIMEOUT   = 1024
) (
  input  logic        fpga_gclk,
  input  logic        reset,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        reg_wr_en,
  output logic [7:0]  reg_wr_addr,
  output logic [15:0] reg_wr_data,
  output logic [3:0]  led_out,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt
);

  localparam int IW = $clog2(MAX_LEN);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] CMD_LED = 8'h01;
  localparam logic [7:0] CMD_REG = 8'h02;

  typedef enum logic [2:0] {HUNT, HDR, PAYLOAD, CHK, COMMIT} state_t;

  state_t        state, state_nxt;
  logic [7:0]    cmd, len, idx, wr_idx;
  logic [15:0]   sum;
  logic [TW-1:0] idle;
  logic [15:0]   pbuf [MAX_LEN];

  logic       accept, hdr_ok, timed, timeout_hit, commit_done;
  logic       abort, commit_start;
  logic [1:0] abort_code;

  assign in_ready    = (state != COMMIT);
  assign accept      = in_valid & in_ready;
  assign hdr_ok      = (in_data[15:8] == CMD_LED && in_data[7:0] == 8'd1) ||
                       (in_data[15:8] == CMD_REG && in_data[7:0] >= 8'd2 &&
                        in_data[7:0] <= 8'(MAX_LEN));
  assign timed       = (state == HDR) || (state == PAYLOAD) || (state == CHK);
  assign timeout_hit = timed && !accept && (idle == TW'(TIMEOUT - 1));
  assign commit_done = (cmd == CMD_LED) || (wr_idx == len - 8'd1);

  always_comb begin
    state_nxt    = state;
    abort        = 1'b0;
    abort_code   = 2'd0;
    commit_start = 1'b0;
    case (state)
      HUNT:    if (accept && in_data == SYNC_WORD) state_nxt = HDR;
      HDR:     if (accept) begin
                 if (hdr_ok) state_nxt = PAYLOAD;
                 else begin
                   abort     = 1'b1;
                   state_nxt = HUNT;
                 end
               end
      PAYLOAD: if (accept && idx == len - 8'd1) state_nxt = CHK;
      CHK:     if (accept) begin
                 if (in_data == sum) begin
                   commit_start = 1'b1;
                   state_nxt    = COMMIT;
                 end else begin
                   abort      = 1'b1;
                   abort_code = 2'd1;
                   state_nxt  = HUNT;
                 end
               end
      COMMIT:  if (commit_done) state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
    if (timeout_hit) begin
      abort      = 1'b1;
      abort_code = 2'd2;
      state_nxt  = HUNT;
    end
  end

  // Payload buffer needs no reset: it is only read after a full frame refills it.
  always_ff @(posedge fpga_gclk) begin
    if (state == PAYLOAD && accept) pbuf[idx[IW-1:0]] <= in_data;
  end

  always_ff @(posedge fpga_gclk or posedge reset) begin
    if (reset) begin
      state       <= HUNT;
      cmd         <= '0;
      len         <= '0;
      idx         <= '0;
      wr_idx      <= '0;
      sum         <= '0;
      idle        <= '0;
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      led_out     <= '0;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= '0;
      frame_cnt   <= '0;
      err_cnt     <= '0;
    end else begin
      state     <= state_nxt;
      reg_wr_en <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      idle      <= (accept || !timed) ? '0 : idle + TW'(1);
      if (state == HDR && accept) begin
        cmd <= in_data[15:8];
        len <= in_data[7:0];
        sum <= in_data;
        idx <= '0;
      end
      if (state == PAYLOAD && accept) begin
        sum <= sum + in_data;
        idx <= idx + 8'd1;
      end
      if (abort) begin
        frame_err <= 1'b1;
        err_code  <= abort_code;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
      if (commit_start) begin
        if (cmd == CMD_LED) begin
          led_out  <= pbuf[IW'(0)][3:0];
          frame_ok <= 1'b1;
        end else begin
          reg_wr_en   <= 1'b1;
          reg_wr_addr <= pbuf[IW'(0)][7:0];
          reg_wr_data <= pbuf[IW'(1)];
          wr_idx      <= 8'd1;
          frame_ok    <= (len == 8'd2);
        end
      end
      // wr_idx counts writes already issued; the last one carries frame_ok.
      if (state == COMMIT) begin
        if (commit_done) begin
          frame_cnt <= frame_cnt + 16'd1;
        end else begin
          reg_wr_en   <= 1'b1;
          reg_wr_addr <= reg_wr_addr + 8'd1;
          reg_wr_data <= pbuf[IW'(wr_idx + 8'd1)];
          wr_idx      <= wr_idx + 8'd1;
          frame_ok    <= (wr_idx + 8'd2 == len);
        end
      end
    end
  end

endmodule
